// File: rtl/weight_wr_ctrl.sv
// weight_wr_ctrl
//   Producer-side controller for the weight-store load path. Packs PARAM_S
//   weights per kernel row into one MSB-justified FIFO word. It writes PARAM_R
//   words into the weight-input FIFO, then requests a weight-store load.
//
// Optional feature macro: WEIGHT_WR_STALL_CNT_EN (adds STALL_CNT output).
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   START, ABORT        begin a load (IDLE only) / cancel and flush the FIFO
//   PARAM_R, PARAM_S    kernel rows / columns, latched on START
//   W_VALID, W_DATA     weight stream in
//   W_READY             weight stream ready (combinational, high in PACK)
//   FIFO_WR_CMD         FIFO write strobe (combinational, WRITE && !FIFO_FULL)
//   FIFO_WR_DATA        packed row word (registered)
//   FIFO_FULL           FIFO full flag
//   CLEAR_FIFO          FIFO flush, high for two cycles after ABORT
//   LOAD_WS, WS_FULL    weight-store load request / consumer full indication
//   BUSY, DONE, ERR     status: not idle / load complete / illegal START
//   STALL_CNT           cycles spent in WRITE with FIFO_FULL (macro only)

module weight_wr_ctrl #(
  parameter int INPUT_WIDTH  = 32,
  parameter int WEIGHT_WIDTH = 8,
  parameter int MAX_R        = 5
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [3:0]              PARAM_R,
  input  logic [3:0]              PARAM_S,
  input  logic                    W_VALID,
  input  logic [WEIGHT_WIDTH-1:0] W_DATA,
  output logic                    W_READY,
  output logic                    FIFO_WR_CMD,
  output logic [INPUT_WIDTH-1:0]  FIFO_WR_DATA,
  input  logic                    FIFO_FULL,
  output logic                    CLEAR_FIFO,
  output logic                    LOAD_WS,
  input  logic                    WS_FULL,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR
`ifdef WEIGHT_WR_STALL_CNT_EN
  ,
  output logic [15:0]             STALL_CNT
`endif
);

  localparam int         LP_BYTES = INPUT_WIDTH / WEIGHT_WIDTH;
  localparam int         LP_IW    = $clog2(INPUT_WIDTH);
  localparam logic [3:0] LP_MAX_R = 4'(MAX_R);
  localparam logic [3:0] LP_MAX_S = 4'(LP_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PACK,
    ST_WRITE,
    ST_LOAD,
    ST_FLUSH
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [3:0]             r_r;
  logic [3:0]             r_s;
  logic [3:0]             r_row;
  logic [3:0]             r_k;
  logic [INPUT_WIDTH-1:0] r_word;
  logic                   r_flush_cnt;

  logic                   r_clear;
  logic                   r_load_ws;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic                   w_legal;
  logic                   w_accept;
  logic                   w_hs;
  logic                   w_wr;
  logic                   w_k_last;
  logic [3:0]             w_row_inc;
  logic [LP_IW-1:0]       w_lsb;

  assign w_legal   = (PARAM_R != 4'd0) && (PARAM_R <= LP_MAX_R) &&
                     (PARAM_S != 4'd0) && (PARAM_S <= LP_MAX_S);
  assign w_accept  = (r_state == ST_IDLE) && START && w_legal;
  assign w_hs      = (r_state == ST_PACK) && W_VALID;
  assign w_wr      = (r_state == ST_WRITE) && !FIFO_FULL;
  assign w_k_last  = (r_k == (r_s - 4'd1));
  assign w_row_inc = r_row + 4'd1;
  // Byte k sits at the top of the word: lsb = W - WW - k*WW.
  assign w_lsb     = LP_IW'(INPUT_WIDTH - WEIGHT_WIDTH - int'(r_k) * WEIGHT_WIDTH);

  assign W_READY      = (r_state == ST_PACK);
  assign FIFO_WR_CMD  = w_wr;
  assign FIFO_WR_DATA = r_word;
  assign CLEAR_FIFO   = r_clear;
  assign LOAD_WS      = r_load_ws;
  assign BUSY         = r_busy;
  assign DONE         = r_done;
  assign ERR          = r_err;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_PACK;
      end
      ST_PACK: begin
        if (ABORT)                  w_next = ST_FLUSH;
        else if (w_hs && w_k_last)  w_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (ABORT)     w_next = ST_FLUSH;
        else if (w_wr) w_next = (w_row_inc == r_r) ? ST_LOAD : ST_PACK;
      end
      ST_LOAD: begin
        if (ABORT)        w_next = ST_FLUSH;
        else if (WS_FULL) w_next = ST_IDLE;
      end
      ST_FLUSH: begin
        if (r_flush_cnt) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_r         <= '0;
      r_s         <= '0;
      r_row       <= '0;
      r_k         <= '0;
      r_word      <= '0;
      r_flush_cnt <= 1'b0;
      r_clear     <= 1'b0;
      r_load_ws   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != ST_IDLE);
      r_load_ws   <= (w_next == ST_LOAD);
      r_clear     <= (w_next == ST_FLUSH);
      r_done      <= (r_state == ST_LOAD) && (w_next == ST_IDLE);
      r_err       <= (r_state == ST_IDLE) && START && !w_legal;
      r_flush_cnt <= (r_state == ST_FLUSH) ? ~r_flush_cnt : 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_r    <= PARAM_R;
            r_s    <= PARAM_S;
            r_row  <= '0;
            r_k    <= '0;
            r_word <= '0;
          end
        end
        ST_PACK: begin
          if (w_hs) begin
            r_word[w_lsb +: WEIGHT_WIDTH] <= W_DATA;
            r_k                           <= r_k + 4'd1;
          end
        end
        ST_WRITE: begin
          if (w_wr) begin
            r_row  <= w_row_inc;
            r_k    <= '0;
            r_word <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WEIGHT_WR_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stall <= '0;
    end else if (w_accept) begin
      r_stall <= '0;
    end else if ((r_state == ST_WRITE) && FIFO_FULL && (r_stall != '1)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign STALL_CNT = r_stall;
`endif

endmodule

// File: tb/tb_weight_wr_ctrl.sv
module tb_weight_wr_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, START, ABORT;
  logic [3:0]  PARAM_R, PARAM_S;
  logic        W_VALID;
  logic [7:0]  W_DATA;
  logic        W_READY, FIFO_WR_CMD;
  logic [31:0] FIFO_WR_DATA;
  logic        FIFO_FULL, CLEAR_FIFO, LOAD_WS, WS_FULL, BUSY, DONE, ERR;
`ifdef WEIGHT_WR_STALL_CNT_EN
  logic [15:0] STALL_CNT;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] wq[$];
  int          done_cnt = 0;
  int          clr_cnt  = 0;
  int          err_cnt  = 0;
  logic [7:0]  wdata [0:19];

  weight_wr_ctrl #(.INPUT_WIDTH(32), .WEIGHT_WIDTH(8), .MAX_R(5)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .ABORT        (ABORT),
    .PARAM_R      (PARAM_R),
    .PARAM_S      (PARAM_S),
    .W_VALID      (W_VALID),
    .W_DATA       (W_DATA),
    .W_READY      (W_READY),
    .FIFO_WR_CMD  (FIFO_WR_CMD),
    .FIFO_WR_DATA (FIFO_WR_DATA),
    .FIFO_FULL    (FIFO_FULL),
    .CLEAR_FIFO   (CLEAR_FIFO),
    .LOAD_WS      (LOAD_WS),
    .WS_FULL      (WS_FULL),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERR          (ERR)
`ifdef WEIGHT_WR_STALL_CNT_EN
    ,
    .STALL_CNT    (STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Capture what the FIFO would see, sampled mid-cycle.
  always @(negedge CLK) begin
    if (FIFO_WR_CMD) wq.push_back(FIFO_WR_DATA);
    if (DONE)        done_cnt++;
    if (CLEAR_FIFO)  clr_cnt++;
    if (ERR)         err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [3:0] r, input logic [3:0] s);
    PARAM_R = r;
    PARAM_S = s;
    START   = 1'b1;
    step;
    START   = 1'b0;
  endtask

  task automatic feed(input int n);
    int  idx   = 0;
    int  guard = 0;
    logic hs;
    W_VALID = 1'b1;
    W_DATA  = wdata[0];
    while (idx < n && guard < 200) begin
      @(negedge CLK);
      hs = W_READY;
      step;
      if (hs) begin
        idx++;
        if (idx < n) W_DATA = wdata[idx];
      end
      guard++;
    end
    W_VALID = 1'b0;
    chk("feed_count", 32'(idx), 32'(n));
  endtask

  task automatic finish_load(input string tag);
    int g = 0;
    while (LOAD_WS !== 1'b1 && g < 60) begin
      step;
      g++;
    end
    chk({tag, "_load_ws"}, 32'(LOAD_WS), 32'd1);
    step;
    chk({tag, "_load_hold"}, 32'(LOAD_WS), 32'd1);
    WS_FULL = 1'b1;
    step;
    WS_FULL = 1'b0;
    chk({tag, "_done"}, 32'(DONE), 32'd1);
    chk({tag, "_load_drop"}, 32'(LOAD_WS), 32'd0);
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
    step;
    chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w_ready"}, 32'(W_READY), 32'd0);
    chk({tag, "_wr_cmd"}, 32'(FIFO_WR_CMD), 32'd0);
    chk({tag, "_wr_data"}, FIFO_WR_DATA, 32'd0);
    chk({tag, "_clear"}, 32'(CLEAR_FIFO), 32'd0);
    chk({tag, "_load_ws"}, 32'(LOAD_WS), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'd0);
    chk({tag, "_err"}, 32'(ERR), 32'd0);
  endtask

  initial begin
    int n;
    int d0, c0, e0;

    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; PARAM_R = '0; PARAM_S = '0;
    W_VALID = 1'b0; W_DATA = '0; FIFO_FULL = 1'b0; WS_FULL = 1'b0;
    repeat (3) step;
    RESET = 1'b0;
    chk_all_zero("reset");

    // R=2, S=3, continuous stream: LOAD_WS rises just after edge 8
    // following the START edge, i.e. it is sampled high at edge 9.
    wq.delete();
    start(4'd2, 4'd3);
    W_VALID = 1'b1;
    W_DATA  = 8'h5A;
    n = 0;
    while (LOAD_WS !== 1'b1 && n < 40) begin
      step;
      n++;
    end
    W_VALID = 1'b0;
    chk("lat_r2s3", 32'(n), 32'd8);
    chk("r2s3_nwr", 32'(wq.size()), 32'd2);
    chk("r2s3_w0", wq[0], 32'h5A5A5A00);
    chk("r2s3_w1", wq[1], 32'h5A5A5A00);
    finish_load("r2s3");
    chk("r2s3_done_cnt", 32'(done_cnt), 32'd1);

    // R=4, S=4 with weights 0x11..0x44
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        wdata[r*4+k] = {4'(r+1), 4'(k+1)};
    wq.delete();
    start(4'd4, 4'd4);
    feed(16);
    finish_load("r4s4");
    chk("r4s4_nwr", 32'(wq.size()), 32'd4);
    chk("r4s4_w0", wq[0], 32'h11121314);
    chk("r4s4_w1", wq[1], 32'h21222324);
    chk("r4s4_w2", wq[2], 32'h31323334);
    chk("r4s4_w3", wq[3], 32'h41424344);
    chk("r4s4_done_cnt", 32'(done_cnt), 32'd2);

    // R=1, S=1
    wdata[0] = 8'hA5;
    wq.delete();
    start(4'd1, 4'd1);
    feed(1);
    finish_load("r1s1");
    chk("r1s1_nwr", 32'(wq.size()), 32'd1);
    chk("r1s1_w0", wq[0], 32'hA5000000);

    // R=3, S=2: low 16 bits stay zero
    for (int i = 0; i < 6; i++) wdata[i] = 8'(i + 1);
    wq.delete();
    start(4'd3, 4'd2);
    feed(6);
    finish_load("r3s2");
    chk("r3s2_nwr", 32'(wq.size()), 32'd3);
    chk("r3s2_w0", wq[0], 32'h01020000);
    chk("r3s2_w1", wq[1], 32'h03040000);
    chk("r3s2_w2", wq[2], 32'h05060000);

    // FIFO_FULL for 5 cycles during the second WRITE (R=2, S=1)
    wq.delete();
    start(4'd2, 4'd1);
    W_VALID = 1'b1;
    W_DATA  = 8'h10;
    step;
    chk("stall_wr1_ready", 32'(W_READY), 32'd0);
    chk("stall_wr1_cmd", 32'(FIFO_WR_CMD), 32'd1);
    W_DATA = 8'h20;
    step;
    FIFO_FULL = 1'b1;
    step;
    W_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_cmd", 32'(FIFO_WR_CMD), 32'd0);
      chk("stall_data", FIFO_WR_DATA, 32'h20000000);
      step;
    end
    FIFO_FULL = 1'b0;
    #1;
    chk("stall_release_cmd", 32'(FIFO_WR_CMD), 32'd1);
    step;
    chk("stall_nwr", 32'(wq.size()), 32'd2);
    chk("stall_w0", wq[0], 32'h10000000);
    chk("stall_w1", wq[1], 32'h20000000);
`ifdef WEIGHT_WR_STALL_CNT_EN
    chk("stall_cnt", 32'(STALL_CNT), 32'd5);
`endif
    finish_load("stall");
    chk("stall_nwr_final", 32'(wq.size()), 32'd2);

    // Illegal START parameters
    wq.delete();
    e0 = err_cnt;
    start(4'd0, 4'd1);
    chk("err_r0", 32'(ERR), 32'd1);
    chk("err_r0_busy", 32'(BUSY), 32'd0);
    step;
    chk("err_r0_pulse", 32'(ERR), 32'd0);
    start(4'd1, 4'd5);
    chk("err_s5", 32'(ERR), 32'd1);
    chk("err_s5_busy", 32'(BUSY), 32'd0);
    step;
    start(4'd6, 4'd2);
    chk("err_r6", 32'(ERR), 32'd1);
    step;
    chk("err_pulses", 32'(err_cnt - e0), 32'd3);
    chk("err_nwr", 32'(wq.size()), 32'd0);
    chk("err_busy", 32'(BUSY), 32'd0);

    // ABORT during PACK of row 2
    wdata[0] = 8'h31; wdata[1] = 8'h32; wdata[2] = 8'h33;
    wq.delete();
    d0 = done_cnt;
    c0 = clr_cnt;
    start(4'd3, 4'd2);
    feed(3);
    chk("abort_in_pack", 32'(W_READY), 32'd1);
    chk("abort_nwr", 32'(wq.size()), 32'd1);
    ABORT = 1'b1;
    step;
    ABORT = 1'b0;
    chk("abort_clr1", 32'(CLEAR_FIFO), 32'd1);
    chk("abort_busy", 32'(BUSY), 32'd1);
    chk("abort_ready", 32'(W_READY), 32'd0);
    step;
    chk("abort_clr2", 32'(CLEAR_FIFO), 32'd1);
    step;
    chk("abort_clr_end", 32'(CLEAR_FIFO), 32'd0);
    chk("abort_idle", 32'(BUSY), 32'd0);
    step;
    chk("abort_clr_cycles", 32'(clr_cnt - c0), 32'd2);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    wdata[0] = 8'hC1; wdata[1] = 8'hC2; wdata[2] = 8'hC3; wdata[3] = 8'hC4;
    wq.delete();
    start(4'd2, 4'd2);
    feed(4);
    finish_load("post_abort");
    chk("post_abort_nwr", 32'(wq.size()), 32'd2);
    chk("post_abort_w0", wq[0], 32'hC1C20000);
    chk("post_abort_w1", wq[1], 32'hC3C40000);

    // START while BUSY is ignored, then RESET during LOAD
    wdata[0] = 8'h77; wdata[1] = 8'h88;
    wq.delete();
    start(4'd2, 4'd1);
    start(4'd1, 4'd1);
    start(4'd0, 4'd0);
    chk("busy_start_no_err", 32'(ERR), 32'd0);
    feed(2);
    n = 0;
    while (LOAD_WS !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    chk("busy_start_load", 32'(LOAD_WS), 32'd1);
    chk("busy_start_nwr", 32'(wq.size()), 32'd2);
    chk("busy_start_w1", wq[1], 32'h88000000);
    RESET = 1'b1;
    step;
    chk_all_zero("rst_load");
    RESET = 1'b0;
    step;
    chk("rst_load_stays_idle", 32'(BUSY), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
